// File: rtl/pcselect.sv
// pcselect: next-PC stage feeding instruction fetch; holds the fetch PC and
// selects redirect / buffered redirect / hold / predicted PC each cycle.
//   clk            core clock, rising edge
//   reset          asynchronous active-low reset
//   predPC         predicted next PC from fetch (sequential +4 or taken target)
//   imem_wait      fetch request outstanding; pc must stay stable
//   stall          hazard-unit stall of fetch
//   redirect_valid execute-stage correction this cycle
//   redirect_pc    corrected target
//   pc             registered fetch PC
//   squashF        instruction fetched at pc is wrong-path
//   redirect_cnt   redirect cycles counted (PCSEL_PERF_EN), else 0
//   wait_cnt       imem_wait cycles counted (PCSEL_PERF_EN), else 0
// Optional feature macro: PCSEL_PERF_EN enables the two performance counters.
module pcselect #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] predPC,
    input  logic        imem_wait,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic [63:0] pc,
    output logic        squashF,
    output logic [31:0] redirect_cnt,
    output logic [31:0] wait_cnt
);
    typedef enum logic {IDLE, PENDING} state_t;

    state_t      r_state, w_state_nxt;
    logic [63:0] r_pc, w_pc_nxt;
    logic [63:0] r_pending_pc, w_pending_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_pc         <= RESET_PC;
            r_pending_pc <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_pending_pc <= w_pending_nxt;
        end
    end

    // A buffered redirect is consumed on the first non-wait cycle regardless
    // of stall, since younger stages were already flushed when it arrived.
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_pending_nxt = r_pending_pc;
        if (imem_wait) begin
            if (redirect_valid) begin
                w_pending_nxt = redirect_pc;
                w_state_nxt   = PENDING;
            end
        end else if (redirect_valid) begin
            w_pc_nxt    = redirect_pc;
            w_state_nxt = IDLE;
        end else if (r_state == PENDING) begin
            w_pc_nxt    = r_pending_pc;
            w_state_nxt = IDLE;
        end else if (!stall) begin
            w_pc_nxt = predPC;
        end
    end

    assign pc      = r_pc;
    assign squashF = redirect_valid | (r_state == PENDING);

`ifdef PCSEL_PERF_EN
    logic [31:0] r_redirect_cnt, r_wait_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_redirect_cnt <= '0;
            r_wait_cnt     <= '0;
        end else begin
            r_redirect_cnt <= r_redirect_cnt + {31'd0, redirect_valid};
            r_wait_cnt     <= r_wait_cnt + {31'd0, imem_wait};
        end
    end

    assign redirect_cnt = r_redirect_cnt;
    assign wait_cnt     = r_wait_cnt;
`else
    assign redirect_cnt = '0;
    assign wait_cnt     = '0;
`endif
endmodule

// File: tb/tb_pcselect.sv
// tb_pcselect: directed self-checking bench for pcselect.
module tb_pcselect;
    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] predPC;
    logic        imem_wait;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [63:0] pc;
    logic        squashF;
    logic [31:0] redirect_cnt;
    logic [31:0] wait_cnt;

    int checks = 0;
    int failures = 0;

    pcselect dut (
        .clk(clk),
        .reset(reset),
        .predPC(predPC),
        .imem_wait(imem_wait),
        .stall(stall),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .pc(pc),
        .squashF(squashF),
        .redirect_cnt(redirect_cnt),
        .wait_cnt(wait_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; predPC = '0; imem_wait = 1'b0; stall = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        step();
        chk("reset_pc", pc, 64'h8000_0000);
        chk("reset_squash", {63'd0, squashF}, 64'd0);
        chk("reset_rcnt", {32'd0, redirect_cnt}, 64'd0);
        chk("reset_wcnt", {32'd0, wait_cnt}, 64'd0);
        reset = 1'b1;
        predPC = 64'h8000_0004;
        step();
        chk("seq0", pc, 64'h8000_0004);
        predPC = 64'h8000_0008;
        step();
        chk("seq1", pc, 64'h8000_0008);
        chk("seq_squash", {63'd0, squashF}, 64'd0);
        // stall hold
        stall = 1'b1; predPC = 64'h8000_000C;
        step(); chk("stall1", pc, 64'h8000_0008);
        step(); chk("stall2", pc, 64'h8000_0008);
        step(); chk("stall3", pc, 64'h8000_0008);
        stall = 1'b0;
        step(); chk("unstall", pc, 64'h8000_000C);
        // immediate redirect beats stall
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_1000;
        #1 chk("imm_squash", {63'd0, squashF}, 64'd1);
        step(); chk("imm_pc", pc, 64'h8000_1000);
        redirect_valid = 1'b0; stall = 1'b0; predPC = 64'h8000_1004;
        // buffered redirect: 4 wait cycles, redirects in cycles 2 and 3
        imem_wait = 1'b1;
        #1 chk("buf_c1_squash", {63'd0, squashF}, 64'd0);
        step(); chk("buf_c1_pc", pc, 64'h8000_1000);
        redirect_valid = 1'b1; redirect_pc = 64'h8000_2000;
        #1 chk("buf_c2_squash", {63'd0, squashF}, 64'd1);
        step(); chk("buf_c2_pc", pc, 64'h8000_1000);
        redirect_pc = 64'h8000_3000;
        step(); chk("buf_c3_pc", pc, 64'h8000_1000);
        redirect_valid = 1'b0;
        #1 chk("buf_c4_squash", {63'd0, squashF}, 64'd1);
        step(); chk("buf_c4_pc", pc, 64'h8000_1000);
        // wait ends with stall high: pending still wins
        imem_wait = 1'b0; stall = 1'b1;
        #1 chk("buf_end_squash", {63'd0, squashF}, 64'd1);
        step(); chk("buf_latest_pc", pc, 64'h8000_3000);
        chk("buf_idle_squash", {63'd0, squashF}, 64'd0);
`ifdef PCSEL_PERF_EN
        chk("perf_rcnt", {32'd0, redirect_cnt}, 64'd3);
        chk("perf_wcnt", {32'd0, wait_cnt}, 64'd4);
`else
        chk("noperf_rcnt", {32'd0, redirect_cnt}, 64'd0);
        chk("noperf_wcnt", {32'd0, wait_cnt}, 64'd0);
`endif
        step(); chk("idle_stall_hold", pc, 64'h8000_3000);
        // fresh redirect beats a pending one
        stall = 1'b0; imem_wait = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_4000;
        step();
        imem_wait = 1'b0; redirect_pc = 64'h8000_5000;
        step(); chk("new_beats_pending", pc, 64'h8000_5000);
        redirect_valid = 1'b0; predPC = 64'h8000_0003;
        step(); chk("misaligned_pass", pc, 64'h8000_0003);
        // async reset while PENDING
        imem_wait = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_6000;
        step();
        redirect_valid = 1'b0;
        #1 chk("pending_squash", {63'd0, squashF}, 64'd1);
        #1 reset = 1'b0;
        #1;
        chk("async_pc", pc, 64'h8000_0000);
        chk("async_squash", {63'd0, squashF}, 64'd0);
        chk("async_rcnt", {32'd0, redirect_cnt}, 64'd0);
        step();
        reset = 1'b1; imem_wait = 1'b0; predPC = 64'h8000_0004;
        step(); chk("pending_discarded", pc, 64'h8000_0004);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pcselect.md
# pcselect

Next-PC stage directly upstream of instruction fetch. Holds the architectural fetch PC register and drives it into the fetch stage each cycle. Each cycle it selects the next PC from three sources: an execute-stage redirect, the fetch stage's predicted PC, or the current PC when held. A redirect that arrives while an instruction-bus request is outstanding is buffered, because the bus address must stay stable until the response returns.

## Interface
Parameters:
- RESET_PC, 64'h8000_0000, PC value loaded on reset.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- predPC  in  64  predicted next PC from fetch (sequential or predicted-taken target).
- imem_wait  in  1  fetch request outstanding; PC must not change.
- stall  in  1  hazard-unit stall of the fetch stage.
- redirect_valid  in  1  execute-stage mispredict / jump correction this cycle.
- redirect_pc  in  64  corrected target; meaningful only when redirect_valid=1.
- pc  out  64  current fetch PC (registered).
- squashF  out  1  the instruction fetched at the current pc is wrong-path; decode must discard it.
- redirect_cnt  out  32  redirects accepted (only with PCSEL_PERF_EN).
- wait_cnt  out  32  cycles with imem_wait=1 (only with PCSEL_PERF_EN).

## Operation
- State machine, two states:
  - IDLE: no buffered redirect.
  - PENDING: a redirect is held in pending_pc, a 64-bit register.
- Next-PC priority, evaluated every cycle:
  1. imem_wait=1 → pc holds.
     - If redirect_valid=1: pending_pc ← redirect_pc, state → PENDING. A redirect arriving in PENDING overwrites pending_pc (latest wins).
  2. imem_wait=0, redirect_valid=1 → pc ← redirect_pc, state → IDLE. This wins over stall and over any pending_pc.
  3. imem_wait=0, state PENDING → pc ← pending_pc, state → IDLE. This ignores stall, since the buffered redirect already flushed younger stages.
  4. imem_wait=0, stall=1 → pc holds.
  5. Otherwise → pc ← predPC.
- squashF = redirect_valid | (state==PENDING). It is combinational, asserted in the same cycle as the condition.
- No alignment check on the PC. A misaligned PC is passed through to fetch, which flags it.
- All PC arithmetic is 64-bit. No increment happens here; sequential +4 is supplied through predPC.

## Timing
- Reset values:
  - pc = RESET_PC.
  - state = IDLE.
  - pending_pc = 0.
  - squashF = 0 (given redirect_valid=0).
  - redirect_cnt = 0 and wait_cnt = 0.
- Reset takes effect immediately on assertion, independent of clk. Release is synchronous to the next rising edge.
- Redirect with imem_wait=0 in cycle N: pc = redirect_pc in cycle N+1.
- Redirect buffered in cycle N during a wait: pc = pending_pc in the cycle after the first cycle with imem_wait=0.
- Reset mid-PENDING: the buffered redirect is discarded and pc returns to RESET_PC.
- imem_wait=1 together with stall=1: hold. A redirect in that cycle is still buffered.

## Configuration
- PCSEL_PERF_EN defined:
  - redirect_cnt increments on every cycle with redirect_valid=1.
  - wait_cnt increments on every cycle with imem_wait=1.
  - Both counters wrap at 2^32 and are reset to 0.
- PCSEL_PERF_EN undefined:
  - Both ports are tied to 0.
  - No counter flops are generated.

## Test plan
- Reset/sequential: release reset, imem_wait=0, stall=0, predPC=pc+4 → pc = 0x80000000, 0x80000004, 0x80000008 on consecutive cycles; squashF=0.
- Stall hold: stall=1 for 3 cycles at pc=0x80000008 → pc remains 0x80000008. Drop stall with predPC=0x8000000C → pc=0x8000000C next cycle.
- Immediate redirect: redirect_valid=1, redirect_pc=0x80001000, stall=1, imem_wait=0 → squashF=1 that cycle; pc=0x80001000 next cycle.
- Buffered redirect:
  - imem_wait=1 for 4 cycles; redirect 0x80002000 in the 2nd cycle and 0x80003000 in the 3rd.
  - Required: pc is held throughout; squashF=1 from the 2nd cycle until the wait ends.
  - Required: after imem_wait drops, pc=0x80003000 on the next edge and state returns to IDLE.
- Async reset mid-PENDING: assert reset=0 between clock edges while PENDING → pc=0x80000000 and squashF=0 immediately, without waiting for a clk edge.
- Perf (PCSEL_PERF_EN): run the buffered-redirect scenario → redirect_cnt=2, wait_cnt=4. Without the macro → both read 0.
